// File: rtl/pong_pkg.sv
// Shared Pong definitions. The game controller and the frame drawer both
// import this package, so they agree on geometry, derived limits and FSM states.
//   - DEF_* : default geometry in pixels, default timing in frames.
//   - helper functions : derive the limits from any parameter set.
//   - derived defaults : 80, 880, 15, 945, 55, 1225.
//   - pong_state_t : encoding of the game FSM.
package pong_pkg;

  localparam int unsigned DEF_FRAME_WIDTH   = 1280;
  localparam int unsigned DEF_FRAME_HEIGHT  = 960;
  localparam int unsigned DEF_CURSOR_WIDTH  = 20;
  localparam int unsigned DEF_CURSOR_OFFSET = 20;
  localparam int unsigned DEF_CURSOR_HEIGHT = 160;
  localparam int unsigned DEF_BALL_SIDE     = 30;
  localparam int unsigned DEF_CURSOR_SPEED  = 8;
  localparam int unsigned DEF_BALL_SPEED    = 4;
  localparam int unsigned DEF_SERVE_FRAMES  = 60;
  localparam int unsigned DEF_MAX_SCORE     = 9;

  // Lowest paddle centre, and lowest ball centre, on an axis.
  function automatic int unsigned half_of(input int unsigned side);
    return side / 2;
  endfunction

  // Highest centre before the object leaves a span of the given extent.
  function automatic int unsigned far_limit(input int unsigned extent,
                                            input int unsigned side);
    return extent - side / 2;
  endfunction

  // Ball centre x when the ball touches the left paddle face.
  function automatic int unsigned left_contact(input int unsigned offset,
                                               input int unsigned width,
                                               input int unsigned side);
    return offset + width + side / 2;
  endfunction

  localparam int unsigned CURSOR_MIN_Y   = half_of(DEF_CURSOR_HEIGHT);
  localparam int unsigned CURSOR_MAX_Y   = far_limit(DEF_FRAME_HEIGHT, DEF_CURSOR_HEIGHT);
  localparam int unsigned BALL_MIN_Y     = half_of(DEF_BALL_SIDE);
  localparam int unsigned BALL_MAX_Y     = far_limit(DEF_FRAME_HEIGHT, DEF_BALL_SIDE);
  localparam int unsigned LEFT_CONTACT_X = left_contact(DEF_CURSOR_OFFSET, DEF_CURSOR_WIDTH,
                                                        DEF_BALL_SIDE);
  localparam int unsigned RIGHT_CONTACT_X = DEF_FRAME_WIDTH - LEFT_CONTACT_X;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } pong_state_t;

endpackage

// File: rtl/pong_paddle.sv
// One Pong paddle: moves its centre y by CURSOR_SPEED per enabled frame and
// clamps it to the playfield.
//   clk, rst (async, active low), en (frame update strobe),
//   up, down (level controls), py (registered paddle centre y).
module pong_paddle
  import pong_pkg::*;
#(
  parameter int unsigned FRAME_HEIGHT  = DEF_FRAME_HEIGHT,
  parameter int unsigned CURSOR_HEIGHT = DEF_CURSOR_HEIGHT,
  parameter int unsigned CURSOR_SPEED  = DEF_CURSOR_SPEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        down,
  output logic [15:0] py
);

  localparam logic [15:0] P_MIN  = 16'(half_of(CURSOR_HEIGHT));
  localparam logic [15:0] P_MAX  = 16'(far_limit(FRAME_HEIGHT, CURSOR_HEIGHT));
  localparam logic [15:0] P_HOME = 16'(FRAME_HEIGHT / 2);
  localparam logic [15:0] STEP   = 16'(CURSOR_SPEED);

  logic [15:0] py_n;

  // Additive comparisons keep the clamp free of unsigned underflow.
  always_comb begin
    py_n = py;
    if (up && !down) begin
      py_n = (py < P_MIN + STEP) ? P_MIN : py - STEP;
    end else if (down && !up) begin
      py_n = (py + STEP > P_MAX) ? P_MAX : py + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      py <= P_HOME;
    end else if (en) begin
      py <= py_n;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve / play / point / game-over sequencing, ball
// motion with wall and paddle reflection, scoring, and two paddles.
//   clk, rst (async, active low), frame_tick (one pulse per frame),
//   start (new game pulse), left_/right_ up/down (paddle controls),
//   cursor_left_py / cursor_right_py, ball_px / ball_py (registered positions),
//   score_left / score_right, serving, game_over (registered status).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH   = DEF_FRAME_WIDTH,
  parameter int unsigned FRAME_HEIGHT  = DEF_FRAME_HEIGHT,
  parameter int unsigned CURSOR_WIDTH  = DEF_CURSOR_WIDTH,
  parameter int unsigned CURSOR_OFFSET = DEF_CURSOR_OFFSET,
  parameter int unsigned CURSOR_HEIGHT = DEF_CURSOR_HEIGHT,
  parameter int unsigned BALL_SIDE     = DEF_BALL_SIDE,
  parameter int unsigned CURSOR_SPEED  = DEF_CURSOR_SPEED,
  parameter int unsigned BALL_SPEED    = DEF_BALL_SPEED,
  parameter int unsigned SERVE_FRAMES  = DEF_SERVE_FRAMES,
  parameter int unsigned MAX_SCORE     = DEF_MAX_SCORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        left_up,
  input  logic        left_down,
  input  logic        right_up,
  input  logic        right_down,
  output logic [15:0] cursor_left_py,
  output logic [15:0] cursor_right_py,
  output logic [15:0] ball_px,
  output logic [15:0] ball_py,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        serving,
  output logic        game_over
);

  localparam logic [15:0] SPD       = 16'(BALL_SPEED);
  localparam logic [15:0] CX        = 16'(FRAME_WIDTH / 2);
  localparam logic [15:0] CY        = 16'(FRAME_HEIGHT / 2);
  localparam logic [15:0] Y_MIN     = 16'(half_of(BALL_SIDE));
  localparam logic [15:0] Y_MAX     = 16'(far_limit(FRAME_HEIGHT, BALL_SIDE));
  localparam logic [15:0] X_MIN     = 16'(half_of(BALL_SIDE));
  localparam logic [15:0] X_MAX     = 16'(far_limit(FRAME_WIDTH, BALL_SIDE));
  localparam logic [15:0] L_CONTACT = 16'(left_contact(CURSOR_OFFSET, CURSOR_WIDTH, BALL_SIDE));
  localparam logic [15:0] R_CONTACT = 16'(FRAME_WIDTH -
                                          left_contact(CURSOR_OFFSET, CURSOR_WIDTH, BALL_SIDE));
  localparam logic [15:0] HIT_SPAN  = 16'(CURSOR_HEIGHT / 2 + BALL_SIDE / 2);
  localparam logic [15:0] SERVE_END = 16'(SERVE_FRAMES - 1);
  localparam logic [3:0]  SCORE_MAX = 4'(MAX_SCORE);

  pong_state_t state, state_n;
  logic [15:0] px_n, py_n, serve_cnt, serve_cnt_n;
  logic [3:0]  score_left_n, score_right_n;
  logic        dx, dy, dx_n, dy_n;
  logic        paddle_en, hit_left, hit_right;

  pong_paddle #(
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .CURSOR_HEIGHT(CURSOR_HEIGHT),
    .CURSOR_SPEED (CURSOR_SPEED)
  ) u_paddle_left (
    .clk (clk),
    .rst (rst),
    .en  (paddle_en),
    .up  (left_up),
    .down(left_down),
    .py  (cursor_left_py)
  );

  pong_paddle #(
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .CURSOR_HEIGHT(CURSOR_HEIGHT),
    .CURSOR_SPEED (CURSOR_SPEED)
  ) u_paddle_right (
    .clk (clk),
    .rst (rst),
    .en  (paddle_en),
    .up  (right_up),
    .down(right_down),
    .py  (cursor_right_py)
  );

  // |ball_py - cursor_py| < HIT_SPAN, written as two additive comparisons.
  assign hit_left  = !dx && (ball_px >= L_CONTACT) && (ball_px < L_CONTACT + SPD) &&
                     (ball_py < cursor_left_py + HIT_SPAN) &&
                     (cursor_left_py < ball_py + HIT_SPAN);
  assign hit_right = dx && (ball_px <= R_CONTACT) && (ball_px + SPD > R_CONTACT) &&
                     (ball_py < cursor_right_py + HIT_SPAN) &&
                     (cursor_right_py < ball_py + HIT_SPAN);

  always_comb begin
    state_n       = state;
    px_n          = ball_px;
    py_n          = ball_py;
    dx_n          = dx;
    dy_n          = dy;
    score_left_n  = score_left;
    score_right_n = score_right;
    serve_cnt_n   = serve_cnt;
    paddle_en     = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_left_n  = '0;
          score_right_n = '0;
          px_n          = CX;
          py_n          = CY;
          serve_cnt_n   = '0;
          state_n       = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          paddle_en = 1'b1;
          px_n      = CX;
          py_n      = CY;
          if (serve_cnt == SERVE_END) begin
            serve_cnt_n = '0;
            state_n     = ST_PLAY;
          end else begin
            serve_cnt_n = serve_cnt + 16'd1;
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          paddle_en = 1'b1;
          // Vertical walls are resolved independently of the paddle/goal
          // tests so a corner tick reflects on both axes.
          if (!dy && (ball_py <= Y_MIN + SPD)) begin
            py_n = Y_MIN;
            dy_n = 1'b1;
          end else if (dy && (ball_py + SPD >= Y_MAX)) begin
            py_n = Y_MAX;
            dy_n = 1'b0;
          end else begin
            py_n = dy ? ball_py + SPD : ball_py - SPD;
          end
          if (hit_left) begin
            px_n = L_CONTACT;
            dx_n = 1'b1;
          end else if (hit_right) begin
            px_n = R_CONTACT;
            dx_n = 1'b0;
          end else if (!dx && (ball_px <= X_MIN + SPD)) begin
            px_n = X_MIN;
            if (score_right != SCORE_MAX) score_right_n = score_right + 4'd1;
            state_n = ST_POINT;
          end else if (dx && (ball_px + SPD >= X_MAX)) begin
            px_n = X_MAX;
            if (score_left != SCORE_MAX) score_left_n = score_left + 4'd1;
            state_n = ST_POINT;
          end else begin
            px_n = dx ? ball_px + SPD : ball_px - SPD;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if ((score_left == SCORE_MAX) || (score_right == SCORE_MAX)) begin
            state_n = ST_OVER;
          end else begin
            // dx still points at the side that missed, i.e. toward the
            // player who conceded, so it is simply kept.
            px_n        = CX;
            py_n        = CY;
            serve_cnt_n = '0;
            state_n     = ST_SERVE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ball_px     <= CX;
      ball_py     <= CY;
      dx          <= 1'b1;
      dy          <= 1'b1;
      score_left  <= '0;
      score_right <= '0;
      serve_cnt   <= '0;
      serving     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      ball_px     <= px_n;
      ball_py     <= py_n;
      dx          <= dx_n;
      dy          <= dy_n;
      score_left  <= score_left_n;
      score_right <= score_right_n;
      serve_cnt   <= serve_cnt_n;
      serving     <= (state_n == ST_SERVE);
      game_over   <= (state_n == ST_OVER);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed serve/paddle/rally/reset
// sequences with literal expectations, then randomized play compared every
// cycle against a behavioural game model kept here.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic [15:0] cursor_left_py, cursor_right_py, ball_px, ball_py;
  logic [3:0]  score_left, score_right;
  logic        serving, game_over;

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .start          (start),
    .left_up        (left_up),
    .left_down      (left_down),
    .right_up       (right_up),
    .right_down     (right_down),
    .cursor_left_py (cursor_left_py),
    .cursor_right_py(cursor_right_py),
    .ball_px        (ball_px),
    .ball_py        (ball_py),
    .score_left     (score_left),
    .score_right    (score_right),
    .serving        (serving),
    .game_over      (game_over)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  string m_mode;
  int m_lp, m_rp, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_serve_ticks;
  int m_left_conceded;
  int m_hits = 0;
  int m_overs = 0;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_mode = "IDLE";
    m_lp = 480; m_rp = 480;
    m_bx = 640; m_by = 480;
    m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0;
    m_serve_ticks = 0;
    m_left_conceded = 0;
  endtask

  task automatic model_step();
    int old_lp, old_rp, nbx, nby, ndx, ndy;
    if (m_mode == "IDLE" || m_mode == "OVER") begin
      if (start) begin
        m_sl = 0; m_sr = 0;
        m_bx = 640; m_by = 480;
        m_serve_ticks = 0;
        m_mode = "SERVE";
      end
      return;
    end
    if (!frame_tick) return;
    old_lp = m_lp;
    old_rp = m_rp;
    if (m_mode == "SERVE" || m_mode == "PLAY") begin
      m_lp = clampi(m_lp + (left_down ? 8 : 0) - (left_up ? 8 : 0), 80, 880);
      m_rp = clampi(m_rp + (right_down ? 8 : 0) - (right_up ? 8 : 0), 80, 880);
    end
    if (m_mode == "SERVE") begin
      m_serve_ticks++;
      if (m_serve_ticks == 60) begin
        m_serve_ticks = 0;
        m_mode = "PLAY";
      end
    end else if (m_mode == "PLAY") begin
      // vertical: would the top/bottom edge reach the frame border?
      ndy = m_dy;
      nby = m_by + (m_dy ? 4 : -4);
      if (m_dy == 0 && m_by - 4 - 15 <= 0) begin
        nby = 15; ndy = 1;
      end else if (m_dy == 1 && m_by + 4 + 15 >= 960) begin
        nby = 945; ndy = 0;
      end
      // horizontal: paddle face contact, else goal line
      ndx = m_dx;
      nbx = m_bx + (m_dx ? 4 : -4);
      if (m_dx == 0 && m_bx >= 55 && m_bx < 59 && absi(m_by - old_lp) < 95) begin
        nbx = 55; ndx = 1; m_hits++;
      end else if (m_dx == 1 && m_bx <= 1225 && m_bx > 1221 && absi(m_by - old_rp) < 95) begin
        nbx = 1225; ndx = 0; m_hits++;
      end else if (m_dx == 0 && m_bx - 4 - 15 <= 0) begin
        nbx = 15;
        m_sr = (m_sr < 9) ? m_sr + 1 : 9;
        m_left_conceded = 1;
        m_mode = "POINT";
      end else if (m_dx == 1 && m_bx + 4 + 15 >= 1280) begin
        nbx = 1265;
        m_sl = (m_sl < 9) ? m_sl + 1 : 9;
        m_left_conceded = 0;
        m_mode = "POINT";
      end
      m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
    end else if (m_mode == "POINT") begin
      if (m_sl == 9 || m_sr == 9) begin
        m_mode = "OVER";
        m_overs++;
      end else begin
        m_bx = 640; m_by = 480;
        m_dx = m_left_conceded ? 0 : 1;
        m_serve_ticks = 0;
        m_mode = "SERVE";
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(posedge clk);
    #1;
    check("cursor_left_py",  int'(cursor_left_py),  m_lp);
    check("cursor_right_py", int'(cursor_right_py), m_rp);
    check("ball_px",         int'(ball_px),         m_bx);
    check("ball_py",         int'(ball_py),         m_by);
    check("score_left",      int'(score_left),      m_sl);
    check("score_right",     int'(score_right),     m_sr);
    check("serving",         int'(serving),         (m_mode == "SERVE") ? 1 : 0);
    check("game_over",       int'(game_over),       (m_mode == "OVER") ? 1 : 0);
  end

  // Drive one cycle at the falling edge, return just after the next rising edge.
  task automatic cyc(input bit tk, input bit st);
    @(negedge clk);
    frame_tick = tk;
    start = st;
    @(posedge clk);
    #2;
    frame_tick = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lp"},   int'(cursor_left_py), 480);
    check({tag, "_rp"},   int'(cursor_right_py), 480);
    check({tag, "_px"},   int'(ball_px), 640);
    check({tag, "_py"},   int'(ball_py), 480);
    check({tag, "_sl"},   int'(score_left), 0);
    check({tag, "_sr"},   int'(score_right), 0);
    check({tag, "_srv"},  int'(serving), 0);
    check({tag, "_over"}, int'(game_over), 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // start coincident with a tick; then 60 serve ticks with left_up held
    // and both right buttons held
    cyc(1'b1, 1'b1);
    check("start_serving", int'(serving), 1);
    left_up = 1'b1; right_up = 1'b1; right_down = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      cyc(1'b1, 1'b0);
      check("serve_flag", int'(serving), (t < 60) ? 1 : 0);
      check("climb_lp", int'(cursor_left_py), (480 - 8 * t < 80) ? 80 : 480 - 8 * t);
      check("both_rp", int'(cursor_right_py), 480);
      check("serve_px", int'(ball_px), 640);
      check("serve_py", int'(ball_py), 480);
    end
    left_up = 1'b0; right_up = 1'b0; right_down = 1'b0;

    // unattended rally: bottom bounce, then right miss
    for (int k = 1; k <= 158; k++) begin
      cyc(1'b1, 1'b0);
      if (k == 1) begin
        check("play1_px", int'(ball_px), 644);
        check("play1_py", int'(ball_py), 484);
      end
      if (k == 117) begin
        check("bounce_px", int'(ball_px), 1108);
        check("bounce_py", int'(ball_py), 945);
      end
      if (k == 157) begin
        check("miss_px", int'(ball_px), 1265);
        check("miss_sl", int'(score_left), 1);
        check("miss_srv", int'(serving), 0);
      end
      if (k == 158) begin
        check("reserve_srv", int'(serving), 1);
        check("reserve_px", int'(ball_px), 640);
      end
    end

    // start during SERVE must not restart the serve count
    for (int t = 1; t <= 60; t++) begin
      cyc(1'b1, (t == 20));
      check("serve_ignore_start", int'(serving), (t < 60) ? 1 : 0);
    end

    // asynchronous reset in the middle of PLAY
    repeat (5) cyc(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b1);
    check("fresh_srv", int'(serving), 1);
    check("fresh_sl", int'(score_left), 0);

    // randomized play
    for (int n = 0; n < 40000; n++) begin
      @(negedge clk);
      frame_tick = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 6) begin
        left_up   = (m_by + 10 < m_lp);
        left_down = (m_by > m_lp + 10);
      end else begin
        left_up   = 1'($urandom_range(0, 1));
        left_down = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) < 6) begin
        right_up   = (m_by + 10 < m_rp);
        right_down = (m_by > m_rp + 10);
      end else begin
        right_up   = 1'($urandom_range(0, 1));
        right_down = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("info: paddle hits %0d, games finished %0d", m_hits, m_overs);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
